data_sym_tx: RTL and testbench

- Transmit end of the 2-bit symbol link (data1, data0, s) that feeds the combinational symbol/state decoder.
- Accepts parallel words over a valid/ready handshake.
- Serializes each word into 2-bit symbols, MSB pair first, and marks the first symbol of each word with s=1.
- Sits between the word source (test driver or register file) and the symbol decoder.

---
 rtl/data_sym_pkg.sv | 23 ++
 rtl/data_sym_tx.sv | 153 +++++++++++++++
 tb/tb_data_sym_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_sym_pkg.sv
// -----------------------------------------------------------------------------
// data_sym_pkg
// Shared definitions for the 2-bit symbol link transmitter (data_sym_tx).
//   state_t   : transmitter state encoding (IDLE / SEND / GAP)
//   SYM_W     : bits carried per symbol (data1, data0)
//   sym_count : number of data symbols needed for a word of a given width
// -----------------------------------------------------------------------------
package data_sym_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SYM_W = 2;

  // Word width is required to be even, so this division is exact.
  function automatic int sym_count(input int word_w);
    return word_w / SYM_W;
  endfunction

endpackage

// File: rtl/data_sym_tx.sv
// -----------------------------------------------------------------------------
// data_sym_tx
// Transmit end of the 2-bit symbol link. Accepts parallel words on a
// valid/ready handshake and serializes each word into 2-bit symbols, MSB pair
// first. The first symbol of every word is flagged with s=1. After a word,
// GAP_CYC idle cycles are forced before the next word (0 = back-to-back).
//
// Optional feature (macro DATA_SYM_PARITY_EN): one extra symbol follows the
// data symbols with data1 = ^word, data0 = ~data1, s=0.
//
// Parameters:
//   WORD_W   word width (even, >= 2); N = WORD_W/2 symbols per word
//   GAP_CYC  idle cycles between words (0..15)
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   source has a word
//   in_ready   out  word can be accepted this cycle (combinational)
//   in_data    in   word to send (sampled only on accept)
//   data1      out  symbol bit 1 (registered)
//   data0      out  symbol bit 0 (registered)
//   s          out  frame-start flag, first symbol of a word (registered)
//   sym_valid  out  data1/data0/s carry a symbol (registered)
//   busy       out  state != IDLE
// -----------------------------------------------------------------------------
module data_sym_tx
  import data_sym_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              data1,
  output logic              data0,
  output logic              s,
  output logic              sym_valid,
  output logic              busy
);

  localparam int N     = sym_count(WORD_W);
  localparam int CNT_W = $clog2(N) + 1;

  state_t            state;
  logic [WORD_W-1:0] shift_reg;   // pairs still to be sent, next pair at the top
  logic [CNT_W-1:0]  sym_cnt;     // data symbols remaining after the one on the outputs
  logic [3:0]        gap_cnt;
  logic              last_sym;    // the word's final symbol is on the outputs now
  logic              b2b_open;
  logic              accept;

`ifdef DATA_SYM_PARITY_EN
  logic par_bit_reg;
  logic par_phase_reg;            // parity symbol is on the outputs
  assign last_sym = par_phase_reg;
`else
  assign last_sym = (sym_cnt == '0);
`endif

  // With no gap the next word may be loaded while the final symbol is showing,
  // so its first symbol follows without a bubble.
  assign b2b_open = (GAP_CYC == 0) && (state == SEND) && last_sym;
  assign in_ready = rst_n && ((state == IDLE) || b2b_open);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // A word always passes through SEND, even when N==1, so that the symbol
  // cycle is never counted as part of the GAP_CYC idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      sym_cnt   <= '0;
      gap_cnt   <= '0;
      data1     <= 1'b0;
      data0     <= 1'b0;
      s         <= 1'b0;
      sym_valid <= 1'b0;
`ifdef DATA_SYM_PARITY_EN
      par_bit_reg   <= 1'b0;
      par_phase_reg <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg <= in_data << SYM_W;
      data1     <= in_data[WORD_W-1];
      data0     <= in_data[WORD_W-2];
      s         <= 1'b1;
      sym_valid <= 1'b1;
      sym_cnt   <= CNT_W'(N - 1);
      state     <= SEND;
`ifdef DATA_SYM_PARITY_EN
      par_bit_reg   <= ^in_data;
      par_phase_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          data1     <= 1'b0;
          data0     <= 1'b0;
          s         <= 1'b0;
          sym_valid <= 1'b0;
        end
        SEND: begin
          if (last_sym) begin
            data1     <= 1'b0;
            data0     <= 1'b0;
            s         <= 1'b0;
            sym_valid <= 1'b0;
`ifdef DATA_SYM_PARITY_EN
            par_phase_reg <= 1'b0;
`endif
            if (GAP_CYC > 0) begin
              gap_cnt <= 4'(GAP_CYC - 1);
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end else if (sym_cnt != '0) begin
            data1     <= shift_reg[WORD_W-1];
            data0     <= shift_reg[WORD_W-2];
            shift_reg <= shift_reg << SYM_W;
            s         <= 1'b0;
            sym_cnt   <= sym_cnt - CNT_W'(1);
          end
`ifdef DATA_SYM_PARITY_EN
          else begin
            data1         <= par_bit_reg;
            data0         <= ~par_bit_reg;
            s             <= 1'b0;
            par_phase_reg <= 1'b1;
          end
`endif
        end
        GAP: begin
          data1     <= 1'b0;
          data0     <= 1'b0;
          s         <= 1'b0;
          sym_valid <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sym_tx.sv
// -----------------------------------------------------------------------------
// tb_data_sym_tx
// Directed bench for data_sym_tx. Instance a uses GAP_CYC=1, instance b uses
// GAP_CYC=0 for the back-to-back case. Expected symbol pairs are written out
// by hand for each word. Honours DATA_SYM_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_data_sym_tx;

`ifdef DATA_SYM_PARITY_EN
  localparam int LEN = 5;
`else
  localparam int LEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid_a = 1'b0, in_ready_a;
  logic [7:0] in_data_a = 8'h00;
  logic       data1_a, data0_a, s_a, sym_valid_a, busy_a;

  logic       in_valid_b = 1'b0, in_ready_b;
  logic [7:0] in_data_b = 8'h00;
  logic       data1_b, data0_b, s_b, sym_valid_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_sym_tx #(.WORD_W(8), .GAP_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .data1(data1_a), .data0(data0_a), .s(s_a),
    .sym_valid(sym_valid_a), .busy(busy_a)
  );

  data_sym_tx #(.WORD_W(8), .GAP_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .data1(data1_b), .data0(data0_b), .s(s_b),
    .sym_valid(sym_valid_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance a and check every symbol, the gap and recovery.
  task automatic send_word(input string tag, input logic [7:0] w,
                           input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input logic [1:0] e3,
                           input logic [1:0] ep);
    logic [1:0] exp_sym [5];
    exp_sym[0] = e0; exp_sym[1] = e1; exp_sym[2] = e2; exp_sym[3] = e3; exp_sym[4] = ep;
    check({tag, "_rdy_pre"}, 8'(in_ready_a), 8'd1);
    in_valid_a = 1'b1;
    in_data_a  = w;
    step();
    in_valid_a = 1'b0;
    in_data_a  = 8'h5A;  // must be ignored
    for (int i = 0; i < LEN; i++) begin
      check($sformatf("%s_vld%0d", tag, i), 8'(sym_valid_a), 8'd1);
      check($sformatf("%s_sym%0d", tag, i), 8'({data1_a, data0_a}), 8'(exp_sym[i]));
      check($sformatf("%s_s%0d", tag, i), 8'(s_a), (i == 0) ? 8'd1 : 8'd0);
      check($sformatf("%s_rdy%0d", tag, i), 8'(in_ready_a), 8'd0);
      step();
    end
    check({tag, "_gap_vld"}, 8'(sym_valid_a), 8'd0);
    check({tag, "_gap_sym"}, 8'({data1_a, data0_a}), 8'd0);
    check({tag, "_gap_rdy"}, 8'(in_ready_a), 8'd0);
    check({tag, "_gap_busy"}, 8'(busy_a), 8'd1);
    step();
    check({tag, "_idle_rdy"}, 8'(in_ready_a), 8'd1);
    check({tag, "_idle_busy"}, 8'(busy_a), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_b;

    // Reset held with in_valid asserted: nothing may be accepted.
    rst_n      = 1'b0;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    in_data_a  = 8'hB4;
    in_data_b  = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_rdy_a%0d", i), 8'(in_ready_a), 8'd0);
      check($sformatf("rst_rdy_b%0d", i), 8'(in_ready_b), 8'd0);
      check($sformatf("rst_vld_a%0d", i), 8'(sym_valid_a), 8'd0);
      check($sformatf("rst_busy_a%0d", i), 8'(busy_a), 8'd0);
      check($sformatf("rst_out_a%0d", i), 8'({data1_a, data0_a, s_a}), 8'd0);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst_n      = 1'b1;
    #1;
    check("rel_rdy_a", 8'(in_ready_a), 8'd1);
    check("rel_rdy_b", 8'(in_ready_b), 8'd1);
    step();
    check("rel_vld_a", 8'(sym_valid_a), 8'd0);

    // Single word 8'hB4 = 10 11 01 00, parity 0 -> 01.
    send_word("b4", 8'hB4, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01);
    // 8'hB5 = 10 11 01 01, parity 1 -> 10.
    send_word("b5", 8'hB5, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10);

    // Stall: in_valid low in IDLE.
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_vld%0d", i), 8'(sym_valid_a), 8'd0);
      check($sformatf("stall_busy%0d", i), 8'(busy_a), 8'd0);
      check($sformatf("stall_s%0d", i), 8'(s_a), 8'd0);
    end

    // Mid-word reset after the 2nd symbol of 8'hB4.
    in_valid_a = 1'b1;
    in_data_a  = 8'hB4;
    step();
    in_valid_a = 1'b0;
    check("mid_sym0", 8'({data1_a, data0_a, s_a}), 8'b101);
    step();
    check("mid_sym1", 8'({data1_a, data0_a, s_a}), 8'b110);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_out", 8'({data1_a, data0_a, s_a}), 8'd0);
    check("mid_async_vld", 8'(sym_valid_a), 8'd0);
    check("mid_async_busy", 8'(busy_a), 8'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_vld", 8'(sym_valid_a), 8'd0);
    step();
    check("mid_after_vld", 8'(sym_valid_a), 8'd0);
    // 8'h1E = 00 01 11 10, parity 0 -> 01.
    send_word("1e", 8'h1E, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01);

    // Back-to-back on instance b: 8'hFF then 8'h00 with in_valid held.
    in_valid_b = 1'b1;
    in_data_b  = 8'hFF;
    step();
    in_data_b  = 8'h00;
    for (int i = 0; i < 2 * LEN; i++) begin
      if (i == LEN) in_valid_b = 1'b0;   // second word was taken on the last edge
      if (i < LEN) exp_b = (i == LEN - 1 && LEN == 5) ? 2'b01 : 2'b11;
      else         exp_b = (i == 2 * LEN - 1 && LEN == 5) ? 2'b01 : 2'b00;
      check($sformatf("b2b_vld%0d", i), 8'(sym_valid_b), 8'd1);
      check($sformatf("b2b_sym%0d", i), 8'({data1_b, data0_b}), 8'(exp_b));
      check($sformatf("b2b_s%0d", i), 8'(s_b), (i == 0 || i == LEN) ? 8'd1 : 8'd0);
      check($sformatf("b2b_rdy%0d", i), 8'(in_ready_b),
            (i == LEN - 1 || i == 2 * LEN - 1) ? 8'd1 : 8'd0);
      step();
    end
    check("b2b_end_vld", 8'(sym_valid_b), 8'd0);
    check("b2b_end_busy", 8'(busy_b), 8'd0);
    check("b2b_end_rdy", 8'(in_ready_b), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
